lcd_text_scheduler: RTL and testbench

- Shares the 2x16 character LCD between NREQ requesters. Each requester writes a full 32-character frame into an internal frame buffer.
- Sequences the existing LCD init/display driver: pulses its reset and init, then streams the 32 buffered characters onto its data input in step with the driver's enable strobe.
- Sits between the host-side text producers and the LCD driver, all in the system clk domain.

---
 rtl/lcd_text_scheduler_pkg.sv | 23 ++
 rtl/lcd_text_scheduler_if.sv | 24 ++
 rtl/lcd_text_scheduler_sig_sync.sv | 26 ++
 rtl/lcd_text_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_lcd_text_scheduler.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_text_scheduler_pkg.sv
// Shared types and constants for the LCD text scheduler: FSM states, frame geometry
// and driver sequencing constants.
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    S_DRV_RST  = 3'd0,
    S_INIT     = 3'd1,
    S_WAIT_CHR = 3'd2,
    S_STREAM   = 3'd3,
    S_IDLE     = 3'd4,
    S_GRANT    = 3'd5
  } sched_state_t;

  localparam int LCD_CHARS  = 32;
  localparam int LCD_LINE   = 16;
  localparam int CHR_ADDR_W = 5;
  localparam int CHR_W      = 8;

  localparam logic [CHR_W-1:0] ASCII_SPACE = 8'h20;

  localparam int DRV_RST_CYC = 2;

endpackage

// File: rtl/lcd_text_scheduler_if.sv
// Requester-side bus of the LCD text scheduler: ownership handshake plus the packed
// per-requester character write port.
interface lcd_text_scheduler_if
  import lcd_sched_pkg::*;
#(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            rel;
  logic [NREQ-1:0]            wr_valid;
  logic [NREQ*CHR_ADDR_W-1:0] wr_addr;
  logic [NREQ*CHR_W-1:0]      wr_data;
  logic [NREQ-1:0]            gnt;

  modport master (
    output req, rel, wr_valid, wr_addr, wr_data,
    input  gnt
  );

  modport slave (
    input  req, rel, wr_valid, wr_addr, wr_data,
    output gnt
  );
endinterface

// File: rtl/lcd_text_scheduler_sig_sync.sv
// Two-flop synchronizer for one driver status line, with single-cycle rise/fall
// pulses taken one stage after the synchronized level.
module lcd_sig_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
    end else begin
      sh <= {sh[1:0], din};
    end
  end

  assign level = sh[1];
  assign rise  = sh[1] & ~sh[2];
  assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/lcd_text_scheduler.sv
// Shares the 2x16 LCD between NREQ requesters and streams the committed frame into
// the LCD driver. Optional grant watchdog: define LCD_SCHED_WATCHDOG_EN.
module lcd_text_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int          NREQ        = 2,
  parameter int          ARB_RR      = 1,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_text_scheduler_if.slave  host,
  output logic                 busy,
  output logic                 lcd_rst,
  output logic                 lcd_init,
  input  logic                 lcd_en_out,
  input  logic                 lcd_rs,
  input  logic                 lcd_init_done,
  output logic [CHR_W-1:0]     lcd_db
`ifdef LCD_SCHED_WATCHDOG_EN
  ,
  output logic                 wd_err
`endif
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int SH_W  = IDX_W + 1;

  sched_state_t          state;
  logic [1:0]            rst_cnt;
  logic [CHR_ADDR_W-1:0] chr_idx;
  logic [IDX_W-1:0]      rr_ptr;
  logic [NREQ-1:0]       gnt_q;
  logic [CHR_W-1:0]      frame_buf [LCD_CHARS];

  logic en_lvl, en_rise, en_fall;
  logic rs_lvl, rs_rise, rs_fall;
  logic done_lvl, done_rise, done_fall;

  lcd_sig_sync u_sync_en (
    .clk   (clk),
    .rst   (rst),
    .din   (lcd_en_out),
    .level (en_lvl),
    .rise  (en_rise),
    .fall  (en_fall)
  );

  lcd_sig_sync u_sync_rs (
    .clk   (clk),
    .rst   (rst),
    .din   (lcd_rs),
    .level (rs_lvl),
    .rise  (rs_rise),
    .fall  (rs_fall)
  );

  lcd_sig_sync u_sync_done (
    .clk   (clk),
    .rst   (rst),
    .din   (lcd_init_done),
    .level (done_lvl),
    .rise  (done_rise),
    .fall  (done_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{en_lvl, en_fall, rs_rise, rs_fall, done_rise};

  // Selected view of the granted requester; all-zero whenever nobody holds a grant.
  logic                  wr_v;
  logic                  rel_g;
  logic                  req_g;
  logic [CHR_ADDR_W-1:0] wr_a;
  logic [CHR_W-1:0]      wr_d;

  always_comb begin
    wr_v  = 1'b0;
    rel_g = 1'b0;
    req_g = 1'b0;
    wr_a  = '0;
    wr_d  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        wr_v  = host.wr_valid[i];
        rel_g = host.rel[i];
        req_g = host.req[i];
        wr_a  = host.wr_addr[i*CHR_ADDR_W +: CHR_ADDR_W];
        wr_d  = host.wr_data[i*CHR_W +: CHR_W];
      end
    end
  end

  // Rotating the doubled request vector puts the round-robin start position at bit 0,
  // so the priority scan only ever uses constant bit positions.
  logic [2*NREQ-1:0] req_rot;
  logic [SH_W-1:0]   rr_shift;
  logic              arb_found;
  logic [IDX_W-1:0]  arb_idx;
  logic [NREQ-1:0]   arb_oh;
  int                cand;

  always_comb begin
    rr_shift  = (ARB_RR != 0) ? ({1'b0, rr_ptr} + SH_W'(1)) : '0;
    req_rot   = {host.req, host.req} >> rr_shift;
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_oh    = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!arb_found && req_rot[k]) begin
        arb_found = 1'b1;
        cand      = (int'(rr_shift) + int'(k)) % NREQ;
        arb_idx   = IDX_W'(cand);
      end
    end
    arb_oh[arb_idx] = arb_found;
  end

  logic wd_fire;

`ifdef LCD_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;

  // rel and req-drop take precedence over a timeout landing in the same cycle.
  assign wd_fire = (state == S_GRANT) && !rel_g && req_g && !wr_v &&
                   (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if ((state == S_GRANT) && !wr_v) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end
      if (wd_fire) begin
        wd_err <= 1'b1;
      end
    end
  end
`else
  assign wd_fire = 1'b0;

  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_DRV_RST;
      rst_cnt <= '0;
      chr_idx <= '0;
      rr_ptr  <= '0;
      gnt_q   <= '0;
    end else begin
      if (state == S_DRV_RST) begin
        rst_cnt <= rst_cnt + 2'd1;
      end else begin
        rst_cnt <= '0;
      end

      unique case (state)
        S_DRV_RST: begin
          if (rst_cnt == 2'(DRV_RST_CYC - 1)) begin
            state <= S_INIT;
          end
        end
        S_INIT: begin
          chr_idx <= '0;
          state   <= S_WAIT_CHR;
        end
        S_WAIT_CHR: begin
          if (done_lvl) begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (en_rise && rs_lvl) begin
            chr_idx <= chr_idx + 5'd1;
          end
          if (done_fall) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (arb_found) begin
            gnt_q <= arb_oh;
            if (ARB_RR != 0) begin
              rr_ptr <= arb_idx;
            end
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (rel_g || wd_fire) begin
            gnt_q <= '0;
            state <= S_DRV_RST;
          end else if (!req_g) begin
            gnt_q <= '0;
            state <= S_IDLE;
          end
        end
        default: begin
          gnt_q <= '0;
          state <= S_DRV_RST;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LCD_CHARS; i++) begin
        frame_buf[i] <= ASCII_SPACE;
      end
    end else if (wr_v) begin
      frame_buf[wr_a] <= wr_d;
    end
  end

  assign host.gnt = gnt_q;
  assign lcd_rst  = (state == S_DRV_RST);
  assign lcd_init = (state == S_INIT);
  assign busy     = (state == S_DRV_RST) || (state == S_INIT) ||
                    (state == S_WAIT_CHR) || (state == S_STREAM);
  assign lcd_db   = frame_buf[chr_idx];

endmodule

// File: tb/tb_lcd_text_scheduler.sv
// Bench for lcd_text_scheduler: LCD driver model plus a frame/arbiter reference model,
// with random writes from granted and non-granted requesters.
module tb_lcd_text_scheduler;
  import lcd_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int TO   = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, lcd_rst, lcd_init;
  logic       lcd_en_out, lcd_rs, lcd_init_done;
  logic [7:0] lcd_db;
`ifdef LCD_SCHED_WATCHDOG_EN
  logic       wd_err;
`endif

  lcd_text_scheduler_if #(.NREQ(NREQ)) hif ();

  lcd_text_scheduler #(
    .NREQ        (NREQ),
    .ARB_RR      (1),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host          (hif.slave),
    .busy          (busy),
    .lcd_rst       (lcd_rst),
    .lcd_init      (lcd_init),
    .lcd_en_out    (lcd_en_out),
    .lcd_rs        (lcd_rs),
    .lcd_init_done (lcd_init_done),
    .lcd_db        (lcd_db)
`ifdef LCD_SCHED_WATCHDOG_EN
    ,
    .wd_err        (wd_err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mdl_buf [32];
  int         mdl_ptr;
  int         granted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_winner(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (mdl_ptr + k) % NREQ;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl_buf[i] = 8'h20;
    mdl_ptr = 0;
    granted = -1;
  endtask

  task automatic strobe(input logic rs, output logic [7:0] d);
    lcd_rs = rs;
    repeat (2) @(negedge clk);
    lcd_en_out = 1'b1;
    d = lcd_db;
    repeat (5) @(negedge clk);
    lcd_en_out = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Driver model for one refresh; abort_at >= 0 stops after that many characters.
  task automatic run_frame(input int abort_at);
    int n_rst, n_init, g;
    logic [7:0] d;
    n_rst = 0; n_init = 0; g = 0;
    while (lcd_init !== 1'b1 && g < 50) begin
      if (lcd_rst === 1'b1) n_rst++;
      @(negedge clk);
      g++;
    end
    check("init_seen", lcd_init, 1);
    check("rst_len", n_rst, 2);
    while (lcd_init === 1'b1 && g < 50) begin
      n_init++;
      @(negedge clk);
      g++;
    end
    check("init_len", n_init, 1);
    check("busy_refresh", busy, 1);
    check("gnt_refresh", hif.gnt, 0);
    repeat (2) strobe(1'b0, d);
    lcd_init_done = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      if (i == abort_at) begin
        repeat (4) @(negedge clk);
        return;
      end
      if (i == 16) strobe(1'b0, d);
      strobe(1'b1, d);
      check($sformatf("chr%0d", i), d, mdl_buf[i]);
    end
    check("busy_stream", busy, 1);
    lcd_init_done = 1'b0;
    lcd_rs = 1'b0;
    g = 0;
    while (busy !== 1'b0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("busy_idle", busy, 0);
  endtask

  task automatic grant(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] oh;
    int w;
    hif.req = r;
    @(negedge clk);
    w = exp_winner(r);
    oh = '0;
    oh[w] = 1'b1;
    check("gnt", hif.gnt, oh);
    check("busy_grant", busy, 0);
    mdl_ptr = w;
    granted = w;
  endtask

  task automatic drive_wr(input int r, input int a, input logic [7:0] dv);
    hif.wr_valid[r] = 1'b1;
    hif.wr_addr[r*5 +: 5] = 5'(a);
    hif.wr_data[r*8 +: 8] = dv;
    if (r == granted) mdl_buf[a] = dv;
  endtask

  task automatic write(input int r, input int a, input logic [7:0] dv);
    drive_wr(r, a, dv);
    @(negedge clk);
    hif.wr_valid = '0;
  endtask

  task automatic commit(input int r, input logic [NREQ-1:0] req_after,
                        input bit with_wr, input int a, input logic [7:0] dv);
    hif.rel[r] = 1'b1;
    hif.req = req_after;
    if (with_wr) drive_wr(r, a, dv);
    @(negedge clk);
    hif.rel = '0;
    hif.wr_valid = '0;
    check("gnt_after_rel", hif.gnt, 0);
    granted = -1;
  endtask

  initial begin
    #900000;
    $display("FAIL sim_time_limit got=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] hello [5];
    int g;
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

    rst = 1'b1;
    lcd_en_out = 1'b0; lcd_rs = 1'b0; lcd_init_done = 1'b0;
    hif.req = '0; hif.rel = '0; hif.wr_valid = '0; hif.wr_addr = '0; hif.wr_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_gnt", hif.gnt, 0);
    check("rst_lcd_init", lcd_init, 0);
    check("rst_lcd_rst", lcd_rst, 1);
    check("rst_busy", busy, 1);
    check("rst_db", lcd_db, 8'h20);
`ifdef LCD_SCHED_WATCHDOG_EN
    check("rst_wd_err", wd_err, 0);
`endif
    rst = 1'b0;
    run_frame(-1);

    // HELLO from requester 0
    grant(2'b01);
    for (int i = 0; i < 5; i++) write(0, i, hello[i]);
    commit(0, 2'b00, 1'b0, 0, 8'h00);
    run_frame(-1);

    // both request: round-robin from pointer 0 picks 1, then 0 stays pending
    grant(2'b11);
    write(1, 20, 8'h5A);
    commit(1, 2'b01, 1'b0, 0, 8'h00);
    run_frame(-1);
    @(negedge clk);
    check("gnt_pending", hif.gnt, 2'b01);
    mdl_ptr = exp_winner(2'b01);
    granted = mdl_ptr;
    write(1, 3, 8'h58);
    write(0, 5, 8'h21);
    commit(0, 2'b00, 1'b0, 0, 8'h00);
    run_frame(-1);

    // random ownership sessions
    for (int it = 0; it < 8; it++) begin
      int nw;
      grant(NREQ'($urandom_range(1, 3)));
      nw = $urandom_range(0, 6);
      for (int k = 0; k < nw; k++)
        write($urandom_range(0, 1), $urandom_range(0, 31), 8'($urandom_range(33, 126)));
      if ($urandom_range(0, 2) == 0) begin
        hif.req = '0;
        @(negedge clk);
        check("gnt_drop", hif.gnt, 0);
        granted = -1;
        repeat (3) @(negedge clk);
        check("busy_drop", busy, 0);
      end else begin
        commit(granted, 2'b00, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
               8'($urandom_range(33, 126)));
        run_frame(-1);
      end
    end

    // reset in the middle of streaming
    grant(2'b10);
    write(1, 10, 8'h51);
    commit(1, 2'b00, 1'b0, 0, 8'h00);
    run_frame(10);
    rst = 1'b1;
    lcd_en_out = 1'b0; lcd_rs = 1'b0; lcd_init_done = 1'b0;
    #1;
    check("midrst_lcd_rst", lcd_rst, 1);
    check("midrst_busy", busy, 1);
    check("midrst_gnt", hif.gnt, 0);
    check("midrst_db", lcd_db, 8'h20);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame(-1);

`ifdef LCD_SCHED_WATCHDOG_EN
    grant(2'b01);
    check("wd_err_before", wd_err, 0);
    g = 0;
    while (hif.gnt != '0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("wd_hold_len", g, TO);
    check("wd_err_set", wd_err, 1);
    hif.req = '0;
    granted = -1;
    run_frame(-1);
    check("wd_err_sticky", wd_err, 1);
`else
    g = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
